fuzz_round_sequencer: RTL
=========================

// Module: fuzz_round_sequencer
// PURPOSE
//  Sequences back-to-back fuzz rounds on one DUT harness. Holds DUT in reset, releases it,
//  watches tohost and the coverage probe, and ends the round on pass or timeout. Then runs
//  the coverage-collect and testcase-reload handshakes and re-enters reset for the next round.
//  Drives the stagnation interrupt (msip) into the core. Sits beside TestHarness, below Testbench.
// PARAMETERS
//  COV_W          30          coverage-sum probe width
//  MAX_WAIT_CYCLE 1000        base stagnation threshold, in cycles
//  SCALE_SHIFT    19          threshold multiplier = (cov >> SCALE_SHIFT) + 1
//  WATCHDOG_LIMIT 50000       cycles in RUN before stall_irq is forced
//  TIMEOUT_CYCLES 2000000000  round length that ends the round as TIMEOUT
//  RESET_HOLD     4           cycles dut_reset is held before each RUN (>=1)
// PORTS
//  clock         in   1      single clock
//  reset         in   1      synchronous, active-high
//  enable        in   1      start sequencing; sampled only in IDLE
//  tohost        in   64     DUT tohost word; bit0 = round pass
//  cov           in   COV_W  coverage-sum probe
//  dut_reset     out  1      reset to TestHarness/DUT
//  stall_irq     out  1      stagnation interrupt to core msip
//  collect_req   out  1      request coverage collection
//  collect_ack   in   1      collection done, one-cycle strobe
//  collect_keep  in   1      valid with collect_ack; 1 = run another round
//  reload_req    out  1      request testcase memory reload and cosim reinit
//  reload_ack    in   1      reload done, one-cycle strobe
//  round_done    out  1      one-cycle pulse when a round ends
//  round_status  out  2      0 none, 1 PASS, 2 TIMEOUT; held until next RUN
//  round_cycles  out  64     cycles spent in RUN this round; held after round ends
//  round_count   out  32     number of rounds entered
//  halted        out  1      sequencing finished
// BEHAVIOUR
//  Reset values:
//   state=IDLE, dut_reset=1, halted=0.
//   All other outputs 0. All counters 0.
//  FSM states: IDLE, HOLD, RUN, COLLECT, RELOAD, HALT. All outputs are registered.
//   IDLE: dut_reset=1. enable=1 -> HOLD and load hold_cnt=RESET_HOLD.
//   HOLD: dut_reset=1; hold_cnt decrements each cycle.
//    At hold_cnt==1 -> RUN next cycle: round_count++, round_cycles=0, round_status=0.
//   RUN: dut_reset=0; round_cycles++ each cycle (saturates at 2^64-1).
//    tohost[0]=1 -> COLLECT, status=PASS, round_done pulse.
//    Else round_cycles+1 >= TIMEOUT_CYCLES -> COLLECT, status=TIMEOUT, round_done pulse.
//    tohost[0] has priority over timeout in the same cycle.
//   COLLECT: dut_reset=1; collect_req=1 until the cycle after collect_ack.
//    On ack, collect_keep=1 -> RELOAD, else -> HALT.
//   RELOAD: reload_req=1 until the cycle after reload_ack.
//    On ack -> HOLD and reload hold_cnt=RESET_HOLD.
//   HALT: dut_reset=1, halted=1. Terminal state; only reset leaves it.
//  Handshake rules:
//   A req rises on state entry and stays high until ack.
//   An ack seen in any other state is ignored.
//   ack on the entry cycle of COLLECT/RELOAD is accepted.
//  Entering RUN:
//   round_status clears; round_cycles restarts at 1 on the first RUN cycle.
//   round_count wraps modulo 2^32.
//  Taking reset mid-round returns to IDLE with dut_reset=1 the next cycle.
//   Any pending req drops.
//  enable deasserted outside IDLE has no effect.
// CONFIGURATION
//  SEQ_STALL_IRQ_EN defined:
//   stag_cnt and wdog_cnt are active in RUN only; both clear in every other state and on reset.
//   stag_cnt: pre_cov<=cov and stag_cnt<=0 when cov!=pre_cov, else stag_cnt++.
//   wdog_cnt increments each RUN cycle. Both counters saturate.
//   stall_irq = (stag_cnt >= MAX_WAIT_CYCLE*((cov>>SCALE_SHIFT)+1))
//               || (wdog_cnt >= WATCHDOG_LIMIT), registered.
//   The threshold product is computed at 64 bits, so no overflow.
//   tohost[0]=1 clears both counters in the same cycle it ends the round.
//  SEQ_STALL_IRQ_EN undefined:
//   stall_irq tied 0; counters and comparators not instantiated.
//   All other behaviour identical.
// TESTING (bench params: TIMEOUT_CYCLES=100, RESET_HOLD=4, MAX_WAIT_CYCLE=10, WATCHDOG_LIMIT=60)
//  1. enable=1 at cycle 0. Expect: dut_reset low from cycle 5, round_count=1.
//     tohost=1 at RUN cycle 20 -> round_done pulse, status=1, round_cycles=20, collect_req next cycle.
//  2. Never set tohost. Expect: RUN for 100 cycles, then round_done with status=2, round_cycles=100.
//  3. tohost[0]=1 on RUN cycle 100. Expect status=1 (PASS wins over TIMEOUT).
//  4. collect_keep=1 on ack. Expect RELOAD, reload_req until ack, 4 HOLD cycles, RUN, round_count=2.
//     collect_keep=0 on ack. Expect HALT, halted=1, dut_reset=1 indefinitely.
//  5. (SEQ_STALL_IRQ_EN) cov held at 5 in RUN. Expect stall_irq=1 after 10 stagnant cycles.
//     cov=1<<19 held. Expect threshold 20.
//     cov changing every cycle. Expect stall_irq at wdog_cnt=60.
//     Macro undefined: stall_irq stays 0.
//  6. reset asserted during RELOAD with reload_req=1. Expect next cycle IDLE, reload_req=0,
//     dut_reset=1, and all counters 0.

Source files
------------

// File: rtl/fuzz_round_sequencer.sv
// Round sequencer for back-to-back fuzz runs: it drives DUT reset, watches tohost and timeout, and runs the collect and reload handshakes.
// Optional stagnation/watchdog interrupt on stall_irq is built only when SEQ_STALL_IRQ_EN is defined.
module fuzz_round_sequencer #(
  parameter int unsigned     COV_W          = 30,
  parameter int unsigned     MAX_WAIT_CYCLE = 1000,
  parameter int unsigned     SCALE_SHIFT    = 19,
  parameter int unsigned     WATCHDOG_LIMIT = 50000,
  parameter longint unsigned TIMEOUT_CYCLES = 64'd2000000000,
  parameter int unsigned     RESET_HOLD     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [63:0]      tohost,
  input  logic [COV_W-1:0] cov,
  output logic             dut_reset,
  output logic             stall_irq,
  output logic             collect_req,
  input  logic             collect_ack,
  input  logic             collect_keep,
  output logic             reload_req,
  input  logic             reload_ack,
  output logic             round_done,
  output logic [1:0]       round_status,
  output logic [63:0]      round_cycles,
  output logic [31:0]      round_count,
  output logic             halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_RUN, S_COLLECT, S_RELOAD, S_HALT
  } state_t;

  localparam logic [1:0] ST_NONE    = 2'd0;
  localparam logic [1:0] ST_PASS    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  localparam int unsigned         HOLD_W       = $clog2(RESET_HOLD + 1);
  localparam logic [HOLD_W-1:0]   HOLD_INIT    = HOLD_W'(RESET_HOLD);
  localparam logic [HOLD_W-1:0]   HOLD_LAST    = HOLD_W'(1);
  // The round ends on the cycle whose increment reaches TIMEOUT_CYCLES.
  localparam logic [63:0]         TIMEOUT_LAST = 64'(TIMEOUT_CYCLES - 64'd1);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              end_pass, end_timeout, start_run;

  // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    end_pass    = 1'b0;
    end_timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_HOLD;
          hold_d  = HOLD_INIT;
        end
      end
      S_HOLD: begin
        hold_d = hold_q - HOLD_LAST;
        if (hold_q == HOLD_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (tohost[0]) begin
          state_d  = S_COLLECT;
          end_pass = 1'b1;
        end else if (round_cycles >= TIMEOUT_LAST) begin
          state_d     = S_COLLECT;
          end_timeout = 1'b1;
        end
      end
      S_COLLECT: begin
        if (collect_ack) state_d = collect_keep ? S_RELOAD : S_HALT;
      end
      S_RELOAD: begin
        if (reload_ack) begin
          state_d = S_HOLD;
          hold_d  = HOLD_INIT;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign start_run = (state_q == S_HOLD) && (state_d == S_RUN);

  // NOTE: reset is synchronous and active-high, so it is tested inside the clocked block rather than in the sensitivity list.
  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      dut_reset    <= 1'b1;
      collect_req  <= 1'b0;
      reload_req   <= 1'b0;
      halted       <= 1'b0;
      round_done   <= 1'b0;
      round_status <= ST_NONE;
      round_cycles <= '0;
      round_count  <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      // Outputs are registered from the next state so they line up with it.
      dut_reset   <= (state_d != S_RUN);
      collect_req <= (state_d == S_COLLECT);
      reload_req  <= (state_d == S_RELOAD);
      halted      <= (state_d == S_HALT);
      round_done  <= end_pass | end_timeout;
      if (start_run) begin
        round_count  <= round_count + 32'd1;
        round_cycles <= '0;
        round_status <= ST_NONE;
      end else if (state_q == S_RUN) begin
        if (round_cycles != '1) round_cycles <= round_cycles + 64'd1;
        if (end_pass)         round_status <= ST_PASS;
        else if (end_timeout) round_status <= ST_TIMEOUT;
      end
    end
  end

`ifdef SEQ_STALL_IRQ_EN
  logic [COV_W-1:0] pre_cov;
  logic [31:0]      stag_cnt, stag_nxt, wdog_cnt, wdog_nxt;
  logic [63:0]      stag_thresh;
  logic             stall_d;
  logic [63:1]      unused_tohost;

  assign unused_tohost = tohost[63:1];

  // Counters only run while the round stays in RUN; leaving RUN (pass or timeout) clears them at once.
  always_comb begin
    stag_nxt = '0;
    wdog_nxt = '0;
    if ((state_q == S_RUN) && (state_d == S_RUN)) begin
      if (cov != pre_cov)       stag_nxt = '0;
      else if (stag_cnt != '1)  stag_nxt = stag_cnt + 32'd1;
      else                      stag_nxt = stag_cnt;
      wdog_nxt = (wdog_cnt != '1) ? wdog_cnt + 32'd1 : wdog_cnt;
    end
    stag_thresh = 64'(MAX_WAIT_CYCLE) * (64'(cov >> SCALE_SHIFT) + 64'd1);
    stall_d     = (64'(stag_nxt) >= stag_thresh) || (wdog_nxt >= WATCHDOG_LIMIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cov   <= '0;
      stag_cnt  <= '0;
      wdog_cnt  <= '0;
      stall_irq <= 1'b0;
    end else begin
      pre_cov   <= cov;
      stag_cnt  <= stag_nxt;
      wdog_cnt  <= wdog_nxt;
      stall_irq <= stall_d;
    end
  end
`else
  logic unused_inputs;

  assign unused_inputs = ^{tohost[63:1], cov};
  assign stall_irq     = 1'b0;
`endif

endmodule
